load_store_unit: RTL and testbench

Memory-access stage load/store unit. Takes the effective address, store data and memory-control fields produced by the execute stage, runs one data-bus transaction per load/store through a request/grant plus response handshake, and returns sign- or zero-extended load data to writeback. Stalls the pipeline while a transaction is outstanding.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_align.sv | 54 +++++
 rtl/load_store_unit.sv | 128 ++++++++++++
 tb/tb_load_store_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: mem_op codes, funct3 width codes, FSM states.
package lsu_pkg;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [2:0] SEL_B  = 3'b000;
  localparam logic [2:0] SEL_H  = 3'b001;
  localparam logic [2:0] SEL_W  = 3'b010;
  localparam logic [2:0] SEL_BU = 3'b100;
  localparam logic [2:0] SEL_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_RSP  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte strobes, replicated store data, extended load data.
// Misalign flag port exists only when LSU_MISALIGN_TRAP_EN is defined.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [1:0]  off,
  input  logic [31:0] sd,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ldata
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b     = rdata[{off, 3'b000} +: 8];
    h     = rdata[{off[1], 4'b0000} +: 16];
    wstrb = 4'b1111;
    wdata = sd;
    ldata = rdata;
    case (sel)
      SEL_B, SEL_BU: begin
        wstrb = 4'b0001 << off;
        wdata = {4{sd[7:0]}};
        ldata = sel[2] ? {24'b0, b} : {{24{b[7]}}, b};
      end
      SEL_H, SEL_HU: begin
        // addr[0] is ignored here, which gives natural-alignment truncation for free
        wstrb = 4'b0011 << {off[1], 1'b0};
        wdata = {2{sd[15:0]}};
        ldata = sel[2] ? {16'b0, h} : {{16{h[15]}}, h};
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    case (sel)
      SEL_B, SEL_BU: misalign = 1'b0;
      SEL_H, SEL_HU: misalign = off[0];
      default:       misalign = (off != 2'b00);
    endcase
  end
`endif

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one bus transaction per op, min 3 cycles accept->result_valid,
// stalls upstream while busy. LSU_MISALIGN_TRAP_EN enables misaligned-access trapping.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [1:0]  mem_op,
  input  logic [2:0]  mem_sel,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  state_e      state, state_d;
  logic [29:0] addr_q;
  logic [2:0]  sel_q;
  logic [1:0]  off_q;
  logic        load_q;
  logic [2:0]  a_sel;
  logic [1:0]  a_off;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_ldata;
  logic        accept, trap;

  assign accept   = (state == S_IDLE) && in_valid &&
                    ((mem_op == OP_LOAD) || (mem_op == OP_STORE));
  // Live fields drive the aligner while idle (strobes/misalign), captured fields afterwards (load lane).
  assign a_sel    = (state == S_IDLE) ? mem_sel   : sel_q;
  assign a_off    = (state == S_IDLE) ? addr[1:0] : off_q;
  assign bus_addr = {addr_q, 2'b00};

`ifdef LSU_MISALIGN_TRAP_EN
  logic al_mis, mis_q;
  assign trap     = al_mis;
  assign misalign = mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_q <= 1'b0;
    else        mis_q <= accept && al_mis;
  end
`else
  assign trap     = 1'b0;
  assign misalign = 1'b0;
`endif

  lsu_align u_align (
    .sel      (a_sel),
    .off      (a_off),
    .sd       (store_data),
    .rdata    (bus_rdata),
    .wstrb    (al_wstrb),
    .wdata    (al_wdata),
    .ldata    (al_ldata)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misalign (al_mis)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    stall   = 1'b0;
    case (state)
      S_IDLE: if (accept) begin
        stall   = 1'b1;
        state_d = trap ? S_DONE : S_REQ;
      end
      S_REQ: begin
        stall = 1'b1;
        if (bus_gnt) state_d = S_RSP;
      end
      S_RSP: begin
        stall = 1'b1;
        if (bus_rvalid) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid <= 1'b0;
      load_data    <= '0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      addr_q       <= '0;
      bus_wdata    <= '0;
      bus_wstrb    <= '0;
      sel_q        <= '0;
      off_q        <= '0;
      load_q       <= 1'b0;
    end else begin
      result_valid <= (state_d == S_DONE);
      if (accept && !trap) begin
        bus_req   <= 1'b1;
        bus_we    <= (mem_op == OP_STORE);
        addr_q    <= addr[31:2];
        bus_wdata <= al_wdata;
        bus_wstrb <= (mem_op == OP_STORE) ? al_wstrb : 4'b0000;
        sel_q     <= mem_sel;
        off_q     <= addr[1:0];
        load_q    <= (mem_op == OP_LOAD);
      end
      if ((state == S_REQ) && bus_gnt) bus_req <= 1'b0;
      if ((state == S_RSP) && bus_rvalid && load_q) load_data <= al_ldata;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: timeline/lane model plus literal pins from the test plan.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  mem_op;
  logic [2:0]  mem_sel;
  logic [31:0] addr, store_data;
  logic        stall, result_valid, misalign;
  logic [31:0] load_data;
  logic        bus_req, bus_gnt, bus_we, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mem_op(mem_op), .mem_sel(mem_sel),
    .addr(addr), .store_data(store_data), .stall(stall), .result_valid(result_valid),
    .load_data(load_data), .misalign(misalign), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  logic        exp_stall, exp_req, exp_rv, exp_mis, exp_we, exp_chk_wd;
  logic [31:0] exp_addr, exp_wd, exp_ld;
  logic [3:0]  exp_strb;

  int cyc, rv_cycle, req_cnt, stall_cnt, rv_cnt, mis_cnt;
  logic [31:0] seen_addr, seen_wd;
  logic [3:0]  seen_strb;
  logic        seen_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Spec-level lane model: shifts and multiplications rather than part-selects.
  function automatic void model(input logic [1:0] op, input logic [2:0] sel,
                                input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                                output logic [3:0] strb, output logic [31:0] wd,
                                output logic [31:0] ld, output logic mis);
    int off, ho;
    logic [31:0] lane;
    off = int'(a[1:0]);
    case (sel)
      3'b000, 3'b100: begin
        lane = (rd >> (8 * off)) & 32'hFF;
        if (sel == 3'b000 && lane >= 32'h80) lane = lane | 32'hFFFFFF00;
        strb = 4'(1 << off);
        wd   = {24'b0, sd[7:0]} * 32'h01010101;
        mis  = 1'b0;
      end
      3'b001, 3'b101: begin
        ho   = (off / 2) * 2;
        lane = (rd >> (8 * ho)) & 32'hFFFF;
        if (sel == 3'b001 && lane >= 32'h8000) lane = lane | 32'hFFFF0000;
        strb = 4'(3 << ho);
        wd   = {16'b0, sd[15:0]} * 32'h00010001;
        mis  = (off % 2) != 0;
      end
      default: begin
        lane = rd;
        strb = 4'hF;
        wd   = sd;
        mis  = off != 0;
      end
    endcase
    if (op != 2'b10) strb = 4'h0;
    ld = lane;
`ifndef LSU_MISALIGN_TRAP_EN
    mis = 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'b0, stall}, {31'b0, exp_stall});
      chk("bus_req", {31'b0, bus_req}, {31'b0, exp_req});
      chk("result_valid", {31'b0, result_valid}, {31'b0, exp_rv});
      chk("misalign", {31'b0, misalign}, {31'b0, exp_mis});
      chk("load_data", load_data, exp_ld);
      if (exp_req) begin
        chk("bus_we", {31'b0, bus_we}, {31'b0, exp_we});
        chk("bus_addr", bus_addr, exp_addr);
        chk("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, exp_strb});
        if (exp_chk_wd) chk("bus_wdata", bus_wdata, exp_wd);
      end
    end
    if (result_valid) begin rv_cycle = cyc; rv_cnt++; end
    if (bus_req) begin
      req_cnt++;
      seen_addr = bus_addr; seen_wd = bus_wdata; seen_strb = bus_wstrb; seen_we = bus_we;
    end
    if (stall) stall_cnt++;
    if (misalign) mis_cnt++;
  end

  task automatic set_idle_exp();
    in_valid = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    exp_stall = 1'b0; exp_req = 1'b0; exp_rv = 1'b0; exp_mis = 1'b0;
  endtask

  task automatic idle(input int n);
    set_idle_exp();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Call at posedge+1 with the DUT idle; g/r are extra wait cycles on grant/response.
  task automatic run_op(input logic [1:0] op, input logic [2:0] sel, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int g, input int r);
    logic [3:0]  e_strb;
    logic [31:0] e_wd, e_ld;
    logic        e_mis;
    int          last;
    model(op, sel, a, sd, rd, e_strb, e_wd, e_ld, e_mis);
    last = e_mis ? 1 : 3 + g + r;
    rv_cycle = -1; req_cnt = 0; stall_cnt = 0; mis_cnt = 0;
    exp_we = (op == 2'b10); exp_addr = {a[31:2], 2'b00};
    exp_strb = e_strb; exp_wd = e_wd; exp_chk_wd = (op == 2'b10);
    for (int c = 0; c <= last; c++) begin
      cyc        = c;
      in_valid   = (c == 0);
      mem_op     = (c == 0) ? op : 2'b00;
      mem_sel    = (c == 0) ? sel : ~sel;
      addr       = (c == 0) ? a : ~a;
      store_data = (c == 0) ? sd : ~sd;
      bus_gnt    = !e_mis && (c == 1 + g);
      bus_rvalid = !e_mis && (c == 2 + g + r);
      bus_rdata  = (c == 2 + g + r) ? rd : (32'h5A5A5A5A ^ 32'(c));
      exp_stall  = e_mis ? (c == 0) : (c <= 2 + g + r);
      exp_req    = !e_mis && (c >= 1) && (c <= 1 + g);
      exp_rv     = (c == last);
      exp_mis    = e_mis && (c == last);
      if (c == last && op == 2'b01 && !e_mis) exp_ld = e_ld;
      @(posedge clk); #1;
    end
    cyc = last + 1;
    set_idle_exp();
  endtask

  int rv_snap;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; mem_op = 2'b00; mem_sel = 3'b000;
    addr = '0; store_data = '0; bus_rdata = '0;
    set_idle_exp();
    exp_ld = '0; exp_we = 1'b0; exp_addr = '0; exp_wd = '0; exp_strb = '0; exp_chk_wd = 1'b0;
    cyc = 0; rv_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_bus_we", {31'b0, bus_we}, 32'd0);
    chk("rst_result_valid", {31'b0, result_valid}, 32'd0);
    chk("rst_misalign", {31'b0, misalign}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_bus_wstrb", {28'b0, bus_wstrb}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // LW, zero-wait bus
    run_op(2'b01, 3'b010, 32'h0000_1000, 32'h0, 32'hDEADBEEF, 0, 0);
    chk("lw_load_data", load_data, 32'hDEADBEEF);
    chk("lw_rv_cycle", rv_cycle, 32'd3);
    chk("lw_stall_cycles", stall_cnt, 32'd3);
    idle(1);

    run_op(2'b01, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0, 0);
    chk("lb_load_data", load_data, 32'hFFFFFF80);
    run_op(2'b01, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0, 0);
    chk("lbu_load_data", load_data, 32'h00000080);

    // Store leaves load_data untouched
    run_op(2'b10, 3'b001, 32'h0000_2002, 32'h1234ABCD, 32'h0, 0, 0);
    chk("sh_bus_we", {31'b0, seen_we}, 32'd1);
    chk("sh_bus_addr", seen_addr, 32'h0000_2000);
    chk("sh_bus_wstrb", {28'b0, seen_strb}, 32'b1100);
    chk("sh_bus_wdata", seen_wd, 32'hABCDABCD);
    chk("sh_load_data_kept", load_data, 32'h00000080);

    run_op(2'b10, 3'b000, 32'h0000_2001, 32'h0000_0055, 32'h0, 1, 0);
    chk("sb_bus_wstrb", {28'b0, seen_strb}, 32'b0010);
    chk("sb_bus_wdata", seen_wd, 32'h55555555);
    run_op(2'b10, 3'b111, 32'h0000_2008, 32'hCAFEF00D, 32'h0, 0, 1);
    chk("sel111_as_w_strb", {28'b0, seen_strb}, 32'b1111);
    run_op(2'b01, 3'b001, 32'h0000_1006, 32'h0, 32'h8001_7FFF, 0, 0);
    chk("lh_load_data", load_data, 32'hFFFF8001);
    run_op(2'b01, 3'b101, 32'h0000_1004, 32'h0, 32'h8001_F00F, 0, 0);
    chk("lhu_load_data", load_data, 32'h0000F00F);

    // Delayed grant (2) and response (3)
    run_op(2'b01, 3'b010, 32'h0000_1000, 32'h0, 32'h0BAD_CAFE, 2, 3);
    chk("slow_rv_cycle", rv_cycle, 32'd8);
    chk("slow_req_cycles", req_cnt, 32'd3);
    chk("slow_load_data", load_data, 32'h0BADCAFE);
    idle(1);

    // Reserved op and none op must not start anything
    req_cnt = 0;
    in_valid = 1'b1; mem_op = 2'b11; mem_sel = 3'b010; addr = 32'h3000;
    @(posedge clk); #1;
    mem_op = 2'b00;
    @(posedge clk); #1;
    idle(2);
    chk("no_op_req_cycles", req_cnt, 32'd0);

    // LW at 0x1002: trapped or truncated depending on build
    run_op(2'b01, 3'b010, 32'h0000_1002, 32'h0, 32'h1357_9BDF, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_req_cycles", req_cnt, 32'd0);
    chk("mis_flag_cycles", mis_cnt, 32'd1);
    chk("mis_rv_cycle", rv_cycle, 32'd1);
    chk("mis_load_data_kept", load_data, 32'h0BADCAFE);
`else
    chk("trunc_bus_addr", seen_addr, 32'h0000_1000);
    chk("trunc_rv_cycle", rv_cycle, 32'd3);
    chk("trunc_load_data", load_data, 32'h13579BDF);
`endif
    run_op(2'b01, 3'b001, 32'h0000_1001, 32'h0, 32'hAAAA_7123, 0, 0);
    idle(1);

    // Reset pulsed during RSP, then a stray response
    rv_snap = rv_cnt;
    in_valid = 1'b1; mem_op = 2'b01; mem_sel = 3'b010; addr = 32'h0000_3000;
    exp_stall = 1'b1; exp_req = 1'b0; exp_rv = 1'b0;
    exp_we = 1'b0; exp_addr = 32'h0000_3000; exp_strb = 4'h0; exp_chk_wd = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; bus_gnt = 1'b1; exp_req = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0; exp_req = 1'b0;
    chk("rsp_stall_before_reset", {31'b0, stall}, 32'd1);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("mid_rst_stall", {31'b0, stall}, 32'd0);
    chk("mid_rst_load_data", load_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_idle_exp();
    exp_ld = '0;
    chk_en = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 32'hBADBAD00;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    idle(3);
    chk("late_rsp_no_result", rv_cnt, rv_snap);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
